// File: rtl/fp_multiplier_pipe.sv
// fp_multiplier_pipe: three-stage pipelined IEEE-754-style multiplier with valid/ready on both sides.
// Define FPMUL_ROUND_EN for round-to-nearest-even; otherwise the fraction is truncated toward zero.
module fp_multiplier_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  localparam int W = 1 + EXP_W + FRAC_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [3:0]   out_flags
);
  localparam int EW = EXP_W + 2;
  localparam int MW = FRAC_W + 1;
  localparam int PW = 2 * FRAC_W + 2;
  localparam logic signed [EW-1:0] BIAS_E = $signed({3'b000, {(EXP_W-1){1'b1}}});
  localparam logic signed [EW-1:0] EMAX_E = $signed({2'b00, {EXP_W{1'b1}}});
  localparam logic signed [EW-1:0] ONE_E  = $signed({{(EW-1){1'b0}}, 1'b1});
  localparam logic signed [EW-1:0] ZERO_E = $signed({EW{1'b0}});

  logic                 w_advance;
  logic [EXP_W-1:0]     w_ea, w_eb;
  logic [FRAC_W-1:0]    w_fa, w_fb;
  logic                 w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic signed [EW-1:0] w_e_sum;
  logic [PW-1:0]        w_prod;

  logic                 r_s1_valid, r_s1_sign, r_s1_invalid, r_s1_inf, r_s1_zero;
  logic signed [EW-1:0] r_s1_e;
  logic [PW-1:0]        r_s1_prod;

  logic [FRAC_W-1:0]    w_frac_t, w_frac_r;
  logic                 w_g, w_s;
  logic signed [EW-1:0] w_e_norm, w_e_r;

  logic                 r_s2_valid, r_s2_sign, r_s2_invalid, r_s2_inf, r_s2_zero, r_s2_inexact;
  logic signed [EW-1:0] r_s2_e;
  logic [FRAC_W-1:0]    r_s2_frac;

  logic [W-1:0]         w_res;
  logic [3:0]           w_flags;
  logic                 r_out_valid;
  logic [W-1:0]         r_out_result;
  logic [3:0]           r_out_flags;

  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance;

  assign w_ea     = in_a[W-2 -: EXP_W];
  assign w_eb     = in_b[W-2 -: EXP_W];
  assign w_fa     = in_a[FRAC_W-1:0];
  assign w_fb     = in_b[FRAC_W-1:0];
  assign w_a_zero = (w_ea == {EXP_W{1'b0}});
  assign w_b_zero = (w_eb == {EXP_W{1'b0}});
  assign w_a_inf  = (w_ea == {EXP_W{1'b1}}) && (w_fa == {FRAC_W{1'b0}});
  assign w_b_inf  = (w_eb == {EXP_W{1'b1}}) && (w_fb == {FRAC_W{1'b0}});
  assign w_a_nan  = (w_ea == {EXP_W{1'b1}}) && (w_fa != {FRAC_W{1'b0}});
  assign w_b_nan  = (w_eb == {EXP_W{1'b1}}) && (w_fb != {FRAC_W{1'b0}});
  assign w_e_sum  = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS_E;
  assign w_prod   = {{(PW-MW){1'b0}}, 1'b1, w_fa} * {{(PW-MW){1'b0}}, 1'b1, w_fb};

  // Stage 1: classify operands, form exponent sum and full mantissa product
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_sign    <= 1'b0;
      r_s1_invalid <= 1'b0;
      r_s1_inf     <= 1'b0;
      r_s1_zero    <= 1'b0;
      r_s1_e       <= ZERO_E;
      r_s1_prod    <= {PW{1'b0}};
    end else if (w_advance) begin
      r_s1_valid   <= in_valid;
      r_s1_sign    <= in_a[W-1] ^ in_b[W-1];
      r_s1_invalid <= w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf);
      r_s1_inf     <= w_a_inf | w_b_inf;
      r_s1_zero    <= w_a_zero | w_b_zero;
      r_s1_e       <= w_e_sum;
      r_s1_prod    <= w_prod;
    end
  end

  // Normalise a product in [1,4) to [1,2) and pick out guard/sticky
  always_comb begin
    w_frac_t = {FRAC_W{1'b0}};
    w_g      = 1'b0;
    w_s      = 1'b0;
    w_e_norm = r_s1_e;
    if (r_s1_prod[PW-1]) begin
      w_frac_t = r_s1_prod[PW-2 -: FRAC_W];
      w_g      = r_s1_prod[FRAC_W];
      w_s      = |r_s1_prod[FRAC_W-1:0];
      w_e_norm = r_s1_e + ONE_E;
    end else begin
      w_frac_t = r_s1_prod[PW-3 -: FRAC_W];
      w_g      = r_s1_prod[FRAC_W-1];
      w_s      = |r_s1_prod[FRAC_W-2:0];
      w_e_norm = r_s1_e;
    end
  end

`ifdef FPMUL_ROUND_EN
  // A carry out of the fraction means it was all ones, so the result becomes 1.0 x 2^(e+1).
  logic              w_inc;
  logic [FRAC_W:0]   w_rnd;
  assign w_inc    = w_g & (w_s | w_frac_t[0]);
  assign w_rnd    = {1'b0, w_frac_t} + {{FRAC_W{1'b0}}, w_inc};
  assign w_frac_r = w_rnd[FRAC_W-1:0];
  assign w_e_r    = w_rnd[FRAC_W] ? (w_e_norm + ONE_E) : w_e_norm;
`else
  assign w_frac_r = w_frac_t;
  assign w_e_r    = w_e_norm;
`endif

  // Stage 2: hold the normalised, rounded significand and exponent
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid   <= 1'b0;
      r_s2_sign    <= 1'b0;
      r_s2_invalid <= 1'b0;
      r_s2_inf     <= 1'b0;
      r_s2_zero    <= 1'b0;
      r_s2_inexact <= 1'b0;
      r_s2_e       <= ZERO_E;
      r_s2_frac    <= {FRAC_W{1'b0}};
    end else if (w_advance) begin
      r_s2_valid   <= r_s1_valid;
      r_s2_sign    <= r_s1_sign;
      r_s2_invalid <= r_s1_invalid;
      r_s2_inf     <= r_s1_inf;
      r_s2_zero    <= r_s1_zero;
      r_s2_inexact <= w_g | w_s;
      r_s2_e       <= w_e_r;
      r_s2_frac    <= w_frac_r;
    end
  end

  // Pack the result, letting special operands and range limits override in priority order
  always_comb begin
    w_res   = {W{1'b0}};
    w_flags = 4'b0000;
    if (r_s2_invalid) begin
      w_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
      w_flags = 4'b1000;
    end else if (r_s2_inf) begin
      w_res   = {r_s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      w_flags = 4'b0000;
    end else if (r_s2_zero) begin
      w_res   = {r_s2_sign, {(W-1){1'b0}}};
      w_flags = 4'b0000;
    end else if (r_s2_e >= EMAX_E) begin
      w_res   = {r_s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      w_flags = 4'b0101;
    end else if (r_s2_e <= ZERO_E) begin
      w_res   = {r_s2_sign, {(W-1){1'b0}}};
      w_flags = 4'b0011;
    end else begin
      w_res   = {r_s2_sign, r_s2_e[EXP_W-1:0], r_s2_frac};
      w_flags = {3'b000, r_s2_inexact};
    end
  end

  // Stage 3: output register, frozen while the consumer stalls
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= {W{1'b0}};
      r_out_flags  <= 4'b0000;
    end else if (w_advance) begin
      r_out_valid  <= r_s2_valid;
      r_out_result <= w_res;
      r_out_flags  <= w_flags;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;
endmodule
